// File: rtl/reg_trace_gen.sv
// reg_trace_gen: trace register block with shadow/active channel config,
// atomic commit, saturating event counter and coherent snapshot reads.
// Ports: usb_clk/reset_n; reg_* front-end bus (read_data registered);
// event_i count input; ch_active_o channel values; commit_pulse_o.
module reg_trace_gen #(
  parameter int         pADDR_WIDTH   = 21,
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pNUM_CH       = 4,
  parameter int         pCH_BYTES     = 4,
  parameter int         pCNT_WIDTH    = 32,
  parameter logic [7:0] pREV          = 8'h01
) (
  input  logic                                  usb_clk,
  input  logic                                  reset_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]              reg_bytecnt,
  output logic [7:0]                            read_data,
  input  logic [7:0]                            write_data,
  input  logic                                  reg_read,
  input  logic                                  reg_write,
  input  logic                                  reg_addrvalid,
  input  logic                                  event_i,
  output logic [pNUM_CH*pCH_BYTES*8-1:0]        ch_active_o,
  output logic                                  commit_pulse_o
);

  localparam int AW  = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int BW  = pBYTECNT_SIZE;
  localparam int CHW = pCH_BYTES * 8;
  localparam int CB  = pCNT_WIDTH / 8;

  localparam logic [AW-1:0] A_REV    = AW'(1);
  localparam logic [AW-1:0] A_TEST   = AW'(2);
  localparam logic [AW-1:0] A_CTRL   = AW'(3);
  localparam logic [AW-1:0] A_STATUS = AW'(4);
  localparam logic [AW-1:0] A_CNT    = AW'(5);

  logic [pNUM_CH-1:0][CHW-1:0] shadow;
  logic [pNUM_CH-1:0][CHW-1:0] active;
  logic [31:0]                 test_q;
  logic [pCNT_WIDTH-1:0]       cnt;
  logic [pCNT_WIDTH-1:0]       snap;
  logic                        cnt_en;
  logic                        dirty;
  logic                        ovf;
  logic                        commit_req;
  logic                        rd;
  logic                        wr;
  logic                        bc0;
  logic                        cnt_clr;
  logic [7:0]                  rd_byte;

  assign rd          = reg_addrvalid & reg_read;
  assign wr          = reg_addrvalid & reg_write;
  assign bc0         = (reg_bytecnt == '0);
  assign cnt_clr     = wr & bc0 & (reg_address == A_CTRL) & write_data[1];
  assign ch_active_o = active;

  always_comb begin
    rd_byte = '0;
    if (bc0) begin
      unique case (1'b1)
        reg_address == A_REV:    rd_byte = pREV;
        reg_address == A_CTRL:   rd_byte = {7'b0, cnt_en};
        reg_address == A_STATUS: rd_byte = {6'b0, ovf, dirty};
        reg_address == A_CNT:    rd_byte = cnt[7:0];
        default: ;
      endcase
    end
    for (int b = 0; b < 4; b++)
      if (reg_address == A_TEST && reg_bytecnt == BW'(b))
        rd_byte = test_q[b*8 +: 8];
    // upper counter bytes come from the snapshot taken at the byte-0 read
    for (int b = 1; b < CB; b++)
      if (reg_address == A_CNT && reg_bytecnt == BW'(b))
        rd_byte = snap[b*8 +: 8];
    for (int c = 0; c < pNUM_CH; c++) begin
      for (int b = 0; b < pCH_BYTES; b++) begin
        if (reg_bytecnt == BW'(b)) begin
          if (reg_address == AW'(16 + c))
            rd_byte = shadow[c][b*8 +: 8];
          if (reg_address == AW'(32 + c))
            rd_byte = active[c][b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data      <= '0;
      test_q         <= '0;
      cnt            <= '0;
      snap           <= '0;
      cnt_en         <= 1'b0;
      dirty          <= 1'b0;
      ovf            <= 1'b0;
      commit_req     <= 1'b0;
      commit_pulse_o <= 1'b0;
      shadow         <= '0;
      active         <= '0;
    end else begin
      read_data <= rd ? rd_byte : 8'h00;

      commit_req <= wr & bc0 & (reg_address == A_CTRL)
                  & write_data[0];
      commit_pulse_o <= commit_req;
      if (commit_req) begin
        active <= shadow;
        dirty  <= 1'b0;
      end

      if (wr && bc0 && reg_address == A_CTRL)
        cnt_en <= write_data[2];

      for (int b = 0; b < 4; b++)
        if (wr && reg_address == A_TEST && reg_bytecnt == BW'(b))
          test_q[b*8 +: 8] <= write_data;

      // placed after the commit so a write racing it stays dirty
      for (int c = 0; c < pNUM_CH; c++) begin
        for (int b = 0; b < pCH_BYTES; b++) begin
          if (wr && reg_address == AW'(16 + c) &&
              reg_bytecnt == BW'(b)) begin
            shadow[c][b*8 +: 8] <= write_data;
            dirty               <= 1'b1;
          end
        end
      end

      if (cnt_en && event_i) begin
        if (&cnt) ovf <= 1'b1;
        else      cnt <= cnt + pCNT_WIDTH'(1);
      end
      if (wr && bc0 && reg_address == A_STATUS && write_data[1])
        ovf <= 1'b0;
      if (cnt_clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end

      if (rd && bc0 && reg_address == A_CNT)
        snap <= cnt;
    end
  end

endmodule

// File: tb/tb_reg_trace_gen.sv
// tb_reg_trace_gen: directed/randomized bench for reg_trace_gen.
// Two instances: default widths and an 8-bit event counter.
module tb_reg_trace_gen;

  localparam int AW = 14;

  logic          usb_clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] reg_address;
  logic [6:0]    reg_bytecnt;
  logic [7:0]    write_data;
  logic          reg_read;
  logic          reg_write;
  logic          reg_addrvalid;
  logic          event_i;
  logic          ev8;
  logic [7:0]    read_data;
  logic [7:0]    read_data8;
  logic [127:0]  ch_active_o;
  logic [127:0]  ch_active8;
  logic          commit_pulse_o;
  logic          commit8;

  int            n_pass = 0;
  int            n_chk  = 0;

  logic          en;
  logic          pend;
  logic          dirty;
  logic          ovf8;
  int            n32;
  int            raw8;
  logic [31:0]   exp_sh [4];
  logic [31:0]   exp_act[4];

  reg_trace_gen u_dut (
    .usb_clk        (usb_clk),
    .reset_n        (reset_n),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .read_data      (read_data),
    .write_data     (write_data),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .event_i        (event_i),
    .ch_active_o    (ch_active_o),
    .commit_pulse_o (commit_pulse_o)
  );

  reg_trace_gen #(.pCNT_WIDTH(8)) u_dut8 (
    .usb_clk        (usb_clk),
    .reset_n        (reset_n),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .read_data      (read_data8),
    .write_data     (write_data),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .event_i        (ev8),
    .ch_active_o    (ch_active8),
    .commit_pulse_o (commit8)
  );

  always #5 usb_clk = ~usb_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] pack_act();
    return {exp_act[3], exp_act[2], exp_act[1], exp_act[0]};
  endfunction

  function automatic logic [7:0] stat8();
    return {6'b0, ovf8, dirty};
  endfunction

  function automatic logic [7:0] stat32();
    return {6'b0, 1'b0, dirty};
  endfunction

  // one bus cycle; expected-state bookkeeping follows the register rules
  task automatic cyc(input logic ev, input logic e8, input logic r,
                     input logic w, input logic [AW-1:0] a,
                     input logic [6:0] bc, input logic [7:0] d);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(bc);
    @(negedge usb_clk);
    event_i       = ev;
    ev8           = e8;
    reg_read      = r;
    reg_write     = w;
    reg_addrvalid = r | w;
    reg_address   = a;
    reg_bytecnt   = bc;
    write_data    = d;
    @(posedge usb_clk);
    if (pend) begin
      for (int c = 0; c < 4; c++) exp_act[c] = exp_sh[c];
      dirty = 1'b0;
    end
    pend = w && ai == 3 && bi == 0 && d[0];
    if (w && ai >= 16 && ai < 20 && bi < 4) begin
      exp_sh[ai-16][bi*8 +: 8] = d;
      dirty = 1'b1;
    end
    if (w && ai == 3 && bi == 0 && d[1]) begin
      n32  = 0;
      raw8 = 0;
      ovf8 = 1'b0;
    end else begin
      if (en && ev) n32++;
      if (en && e8) begin
        if (raw8 >= 255) ovf8 = 1'b1;
        raw8++;
      end
      if (w && ai == 4 && bi == 0 && d[1]) ovf8 = 1'b0;
    end
    if (w && ai == 3 && bi == 0) en = d[2];
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [6:0] bc);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, a, bc, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [6:0] bc,
                    input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, a, bc, d);
  endtask

  task automatic model_reset();
    en    = 1'b0;
    pend  = 1'b0;
    dirty = 1'b0;
    ovf8  = 1'b0;
    n32   = 0;
    raw8  = 0;
    for (int c = 0; c < 4; c++) begin
      exp_sh[c]  = '0;
      exp_act[c] = '0;
    end
  endtask

  initial begin
    logic [31:0] tv;
    logic [31:0] snap;
    logic [31:0] live;
    logic [7:0]  exp8;
    logic [7:0]  r8;
    int          p;
    int          pulses;
    bit          e;

    reset_n       = 1'b0;
    event_i       = 1'b0;
    ev8           = 1'b0;
    reg_read      = 1'b0;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
    reg_address   = '0;
    reg_bytecnt   = '0;
    write_data    = '0;
    model_reset();
    repeat (3) @(posedge usb_clk);
    #1;
    chk("rst_read_data", 128'(read_data), 0);
    chk("rst_read_data8", 128'(read_data8), 0);
    chk("rst_ch_active", ch_active_o, 0);
    chk("rst_commit", 128'(commit_pulse_o), 0);
    @(negedge usb_clk);
    reset_n = 1'b1;

    // identification and scratch
    rd(AW'(1), 7'd0);
    chk("rev", 128'(read_data), 128'h01);
    idle();
    chk("no_read_zero", 128'(read_data), 0);
    for (int b = 0; b < 4; b++) begin
      rd(AW'(2), 7'(b));
      chk("test_reset", 128'(read_data), 0);
    end
    tv = $urandom;
    for (int b = 0; b < 4; b++) wr(AW'(2), 7'(b), tv[b*8 +: 8]);
    for (int b = 0; b < 4; b++) begin
      rd(AW'(2), 7'(b));
      chk("test_rw", 128'(read_data), 128'(tv[b*8 +: 8]));
    end

    // shadow writes, then commit
    for (int c = 0; c < 4; c++) begin
      tv = (c == 2) ? 32'hDEADBEEF : $urandom;
      for (int b = 0; b < 4; b++)
        wr(AW'(16 + c), 7'(b), tv[b*8 +: 8]);
      if (c == 2) begin
        rd(AW'(4), 7'd0);
        chk("status_dirty", 128'(read_data), 128'h01);
        chk("active_before_commit", ch_active_o, 0);
      end
    end
    rd(AW'(17), 7'd3);
    chk("shadow_rd", 128'(read_data), 128'(exp_sh[1][31:24]));
    wr(AW'(3), 7'd0, 8'h01);
    pulses = int'(commit_pulse_o);
    repeat (4) begin
      idle();
      pulses += int'(commit_pulse_o);
    end
    chk("commit_one_pulse", 128'(pulses), 128'd1);
    chk("active_after_commit", ch_active_o, pack_act());
    chk("active_ch2", 128'(ch_active_o[95:64]), 128'hDEADBEEF);
    rd(AW'(4), 7'd0);
    chk("status_clean", 128'(read_data), 128'h00);
    tv = 32'hDEADBEEF;
    for (int b = 0; b < 4; b++) begin
      rd(AW'(34), 7'(b));
      chk("active_rd", 128'(read_data), 128'(tv[b*8 +: 8]));
    end

    // active registers are read-only
    wr(AW'(32), 7'd0, 8'h5A);
    idle();
    chk("active_ro", ch_active_o, pack_act());
    rd(AW'(4), 7'd0);
    chk("status_ro_write", 128'(read_data), 128'(stat32()));

    // shadow write while the pulse is high is not committed
    wr(AW'(17), 7'd0, 8'($urandom));
    wr(AW'(3), 7'd0, 8'h01);
    idle();
    chk("pulse_high", 128'(commit_pulse_o), 128'd1);
    wr(AW'(17), 7'd1, 8'($urandom));
    chk("late_write_active", ch_active_o, pack_act());
    rd(AW'(4), 7'd0);
    chk("late_write_dirty", 128'(read_data), 128'h01);

    // back-to-back commits
    wr(AW'(3), 7'd0, 8'h01);
    pulses = int'(commit_pulse_o);
    wr(AW'(3), 7'd0, 8'h01);
    pulses += int'(commit_pulse_o);
    repeat (4) begin
      idle();
      pulses += int'(commit_pulse_o);
    end
    chk("b2b_pulses", 128'(pulses), 128'd2);
    chk("b2b_active", ch_active_o, pack_act());
    rd(AW'(4), 7'd0);
    chk("b2b_status", 128'(read_data), 128'h00);

    // event counter with random spacing, then snapshot read
    wr(AW'(3), 7'd0, 8'h04);
    rd(AW'(3), 7'd0);
    chk("ctrl_rd", 128'(read_data), 128'h01);
    p = 0;
    while (p < 300) begin
      e = 1'($urandom_range(0, 1));
      cyc(e, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (e) p++;
    end
    snap = 32'(n32);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, AW'(5), 7'd0, '0);
    chk("snap_b0", 128'(read_data), 128'(snap[7:0]));
    for (int b = 1; b < 4; b++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, AW'(5), 7'(b), '0);
      chk("snap_bn", 128'(read_data), 128'(snap[b*8 +: 8]));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, AW'(5), 7'd4, '0);
    chk("snap_b4_zero", 128'(read_data), 0);
    live = 32'(n32);
    rd(AW'(5), 7'd0);
    chk("live_b0", 128'(read_data), 128'(live[7:0]));
    rd(AW'(5), 7'd1);
    chk("live_b1", 128'(read_data), 128'(live[15:8]));

    // disabled counter holds
    wr(AW'(3), 7'd0, 8'h00);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    live = 32'(n32);
    rd(AW'(5), 7'd0);
    chk("frozen_b0", 128'(read_data), 128'(live[7:0]));

    // 8-bit counter saturation and OVF
    wr(AW'(3), 7'd0, 8'h04);
    repeat (260) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    exp8 = (raw8 > 255) ? 8'hFF : raw8[7:0];
    rd(AW'(5), 7'd0);
    chk("sat8_count", 128'(read_data8), 128'(exp8));
    chk("sat8_const", 128'(read_data8), 128'hFF);
    rd(AW'(4), 7'd0);
    chk("sat8_ovf", 128'(read_data8), 128'(stat8()));
    chk("cnt32_no_ovf", 128'(read_data), 128'(stat32()));
    r8 = stat8();
    chk("sat8_ovf_bit", 128'(r8[1]), 128'd1);
    wr(AW'(4), 7'd0, 8'h02);
    rd(AW'(4), 7'd0);
    chk("ovf8_cleared", 128'(read_data8), 128'(stat8()));
    rd(AW'(5), 7'd0);
    chk("sat8_hold", 128'(read_data8), 128'hFF);

    // clear wins over a same-cycle event
    cyc(1'b1, 1'b1, 1'b0, 1'b1, AW'(3), 7'd0, 8'h06);
    rd(AW'(5), 7'd0);
    chk("clr_cnt32", 128'(read_data), 0);
    chk("clr_cnt8", 128'(read_data8), 0);
    rd(AW'(4), 7'd0);
    chk("clr_status8", 128'(read_data8), 128'(stat8()));
    repeat (12) begin
      e = 1'($urandom_range(0, 1));
      cyc(e, e, 1'b0, 1'b0, '0, '0, '0);
    end
    live = 32'(n32);
    rd(AW'(5), 7'd0);
    chk("post_clr_cnt", 128'(read_data), 128'(live[7:0]));

    // out-of-range and unmapped accesses
    rd(AW'('h7F), 7'd0);
    chk("unmapped_7f", 128'(read_data), 0);
    rd(AW'('h15), 7'd0);
    chk("shadow_ch5", 128'(read_data), 0);
    rd(AW'('h24), 7'd0);
    chk("active_ch4", 128'(read_data), 0);
    rd(AW'(2), 7'd9);
    chk("test_bc9", 128'(read_data), 0);
    rd(AW'(1), 7'd1);
    chk("rev_bc1", 128'(read_data), 0);
    repeat (4) begin
      rd(AW'($urandom_range(64, 16383)), 7'($urandom_range(0, 127)));
      chk("unmapped_rand", 128'(read_data), 0);
    end
    wr(AW'(2), 7'd9, 8'hFF);
    wr(AW'(19), 7'd4, 8'hFF);
    rd(AW'(4), 7'd0);
    chk("oob_write_clean", 128'(read_data), 128'(stat32()));

    // asynchronous reset during the commit pulse
    wr(AW'(3), 7'd0, 8'h01);
    idle();
    chk("pre_reset_pulse", 128'(commit_pulse_o), 128'd1);
    chk("pre_reset_active", ch_active_o, pack_act());
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_pulse", 128'(commit_pulse_o), 0);
    chk("async_rst_active", ch_active_o, 0);
    model_reset();
    @(negedge usb_clk);
    reset_n = 1'b1;
    rd(AW'(4), 7'd0);
    chk("post_rst_status", 128'(read_data), 0);
    rd(AW'(2), 7'd0);
    chk("post_rst_test", 128'(read_data), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_trace_gen.md
Name: reg_trace_gen

Overview:
- Parametrised next-generation register block for the trace subsystem, driven by the cw305_usb_reg_fe front end on usb_clk.
- Provides pNUM_CH multi-byte channel configuration registers with a shadow/active double-buffer and an atomic commit.
- Provides a saturating event counter with atomic multi-byte snapshot reads.
- Also holds identification and scratch registers. Active channel values drive the trace core directly.

Parameters:
pADDR_WIDTH, 21, full register address width from the front end
pBYTECNT_SIZE, 7, byte-count field width
pNUM_CH, 4, number of channel config registers (1..16)
pCH_BYTES, 4, bytes per channel register (1..8)
pCNT_WIDTH, 32, event counter width (8..64, multiple of 8)
pREV, 8'h01, value returned by REG_REV

Ports:
usb_clk  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register address
reg_bytecnt  in  pBYTECNT_SIZE  byte index within register
read_data  out  8  read byte
write_data  in  8  write byte
reg_read  in  1  read strobe
reg_write  in  1  write strobe
reg_addrvalid  in  1  address valid qualifier
event_i  in  1  event pulse, synchronous to usb_clk; one count per high cycle
ch_active_o  out  pNUM_CH*pCH_BYTES*8  active channel values; channel n at bits [n*pCH_BYTES*8 +: pCH_BYTES*8]
commit_pulse_o  out  1  one-cycle pulse when active values update

Behaviour:
- Clock and reset: single clock usb_clk; reset is asynchronous, active-low (reset_n).
- Reset state: all registers and outputs are 0, including read_data, ch_active_o, commit_pulse_o, shadows, counter, snapshot, status and scratch.
- Register map (reg_address values, compared zero-extended):
  - 0x01 REG_REV: 1 byte, read-only, returns pREV.
  - 0x02 REG_TEST: 4 bytes, read/write scratch.
  - 0x03 REG_CTRL: bit0 COMMIT (self-clearing), bit1 CNT_CLR (self-clearing), bit2 CNT_EN (held). Reads return {5'b0, 1'b0, 1'b0, CNT_EN}.
  - 0x04 REG_STATUS: bit0 DIRTY (read-only), bit1 OVF (sticky; write 1 to clear).
  - 0x05 REG_EVCOUNT: pCNT_WIDTH/8 bytes, read-only.
  - 0x10+n REG_CH_SHADOW[n]: pCH_BYTES bytes, read/write.
  - 0x20+n REG_CH_ACTIVE[n]: pCH_BYTES bytes, read-only.
- Read path:
  - read_data is registered: the value for a cycle with reg_addrvalid && reg_read appears on the next clock edge.
  - read_data returns 0 in every cycle without a qualified read.
  - Unmapped addresses, bytecnt beyond the register size, and channel n >= pNUM_CH all read 0.
- Write path:
  - A write takes effect on the edge where reg_addrvalid && reg_write is high.
  - Writes to read-only or unmapped addresses, or with out-of-range bytecnt, are ignored with no side effects.
- Shadow/commit:
  - Any shadow write sets DIRTY.
  - A REG_CTRL write with bit0=1 loads every active channel from its shadow on the following edge.
  - On that same edge commit_pulse_o goes high for exactly one cycle and DIRTY clears.
  - ch_active_o never changes except on commit or reset.
  - A shadow write in the cycle commit_pulse_o is high sets DIRTY again; that new value is not committed.
  - Back-to-back COMMIT writes produce one pulse per write.
- Event counter:
  - When CNT_EN=1 and event_i=1, the counter increments by 1.
  - At all-ones the counter saturates: it holds the value and sets OVF.
  - OVF stays set until cleared by a STATUS write of 1 to bit1, or by CNT_CLR.
  - CNT_CLR zeroes the counter and OVF on the write edge. If event_i is high in the same cycle, clear wins and the result is 0.
  - CNT_EN=0 freezes the counter.
- Atomic snapshot:
  - A qualified read of REG_EVCOUNT with bytecnt=0 returns byte 0 of the live counter and, on the same edge, copies the live counter into the snapshot.
  - Reads with bytecnt>0 return the corresponding snapshot bytes.
  - A multi-byte read therefore returns one coherent value even while events arrive.
- Simultaneous events: the front end issues one access per cycle, so read and write never coincide. A counter increment concurrent with a snapshot read is captured as the pre-increment value.
- Reset mid-operation: asserting reset_n low immediately zeroes all state asynchronously, including a pending commit_pulse_o. Release is synchronous to usb_clk.

Test Plan:
- Reset, then read REV and TEST -> read_data 0x01, then TEST bytes 0x00; all outputs 0.
- pNUM_CH=4, pCH_BYTES=4: write CH_SHADOW[2]=0xDEADBEEF, then read STATUS -> 0x01 and ch_active_o==0. Write CTRL=0x01 -> exactly one commit_pulse_o cycle; ch_active_o[95:64]=0xDEADBEEF; STATUS reads 0x00; CH_ACTIVE[2] reads EF,BE,AD,DE.
- CTRL=0x04, drive 300 event_i pulses, then read EVCOUNT bytes 0..3 while pulsing event_i every cycle -> returns 0x0000012C plus the pulses before the byte-0 read edge, constant across bytes 1..3.
- pCNT_WIDTH=8: 260 events -> count 0xFF, STATUS.OVF=1. Write STATUS=0x02 -> OVF=0, count stays 0xFF.
- CTRL=0x06 with event_i high in the same cycle -> count 0, OVF 0.
- Read address 0x7F, CH_SHADOW[5], and TEST bytecnt 9 -> 0. Write to CH_ACTIVE[0] -> ch_active_o unchanged. Pull reset_n low mid-commit -> commit_pulse_o and ch_active_o drop to 0 without a clock edge.
